// File: rtl/renode_apb3_pkg.sv
// Shared types and helpers for the Renode-facing APB3 completer slice.
package renode_apb3_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } apb3_completer_state_t;

  // Decode cause of the current access; kept as an enum so it is readable in waves.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2
  } apb3_err_e;

  localparam int unsigned WAIT_CNT_W = 32'd4;

  function automatic int unsigned apb3_bytes_log2(input int unsigned data_width);
    int unsigned res;
    case (data_width)
      32'd8:   res = 32'd0;
      32'd16:  res = 32'd1;
      32'd32:  res = 32'd2;
      32'd64:  res = 32'd3;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/apb3_mem_completer_chk.sv
// Elaboration-time parameter legality checks for apb3_mem_completer.
module apb3_mem_completer_chk
  import renode_apb3_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned DepthWords  = 256,
  parameter int unsigned BaseAddress = 0,
  parameter int unsigned WaitStates  = 0
) ();

  localparam int unsigned ALIGN_BYTES = 32'd1 << apb3_bytes_log2(DataWidth);

  if (!(DataWidth == 32'd8 || DataWidth == 32'd16 || DataWidth == 32'd32 || DataWidth == 32'd64)) begin : g_bad_data_width
    $error("apb3_mem_completer: DataWidth must be 8, 16, 32 or 64");
  end

  if (DepthWords < 32'd1) begin : g_bad_depth
    $error("apb3_mem_completer: DepthWords must be at least 1");
  end

  if (WaitStates > 32'd15) begin : g_bad_wait
    $error("apb3_mem_completer: WaitStates must be 0..15");
  end

  if ((BaseAddress % ALIGN_BYTES) != 32'd0) begin : g_bad_base
    $error("apb3_mem_completer: BaseAddress must be word aligned");
  end

endmodule

// File: rtl/apb3_word_ram.sv
// Reset-to-zero word storage: one synchronous write port, one asynchronous read port.
module apb3_word_ram #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned DepthWords = 256,
  parameter int unsigned IdxWidth   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IdxWidth-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [IdxWidth-1:0]  raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem_r [DepthWords];

  // Storage array: cleared on reset, written when the completer commits a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DepthWords); i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb3_mem_completer.sv
// APB3 completer with word storage, fixed wait states and range/alignment error responses.
module apb3_mem_completer
  import renode_apb3_pkg::*;
#(
  parameter int unsigned AddressWidth = 20,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned DepthWords   = 256,
  parameter int unsigned BaseAddress  = 0,
  parameter int unsigned WaitStates   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DataWidth-1:0]    pwdata,
  output logic                    pready,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pslverr
);

  localparam int unsigned LSB   = apb3_bytes_log2(DataWidth);
  localparam int unsigned IDX_W = (DepthWords > 32'd1) ? $clog2(DepthWords) : 32'd1;
  localparam logic [AddressWidth-1:0] BASE_ADDR  = AddressWidth'(BaseAddress);
  localparam logic [AddressWidth-1:0] ALIGN_MASK = AddressWidth'((64'd1 << LSB) - 64'd1);
  localparam logic [AddressWidth:0]   DEPTH_LIM  = (AddressWidth + 1)'(DepthWords);
  localparam logic [WAIT_CNT_W-1:0]   WAIT_INIT  = WAIT_CNT_W'(WaitStates);

  apb3_completer_state_t   state_r;
  logic [WAIT_CNT_W-1:0]   wait_cnt_r;
  logic [AddressWidth-1:0] addr_r;
  logic                    write_r;
  logic [DataWidth-1:0]    wdata_r;
  logic                    pready_r;

  logic [AddressWidth-1:0] offset_s;
  logic [AddressWidth-1:0] index_s;
  apb3_err_e               err_s;
  logic                    we_s;
  logic [DataWidth-1:0]    rd_data_s;

  apb3_mem_completer_chk #(
    .DataWidth  (DataWidth),
    .DepthWords (DepthWords),
    .BaseAddress(BaseAddress),
    .WaitStates (WaitStates)
  ) u_chk ();

  // Address decode of the latched request into word index and error cause.
  always_comb begin
    offset_s = addr_r - BASE_ADDR;
    index_s  = offset_s >> LSB;
    if (addr_r < BASE_ADDR) begin
      err_s = ERR_RANGE;
    end else if ({1'b0, index_s} >= DEPTH_LIM) begin
      err_s = ERR_RANGE;
    end else if ((addr_r & ALIGN_MASK) != '0) begin
      err_s = ERR_ALIGN;
    end else begin
      err_s = ERR_NONE;
    end
  end

  // pready_r is only high in the final access cycle, so psel there means a genuine completion.
  assign we_s = pready_r && psel && write_r && (err_s == ERR_NONE);

  apb3_word_ram #(
    .DataWidth (DataWidth),
    .DepthWords(DepthWords),
    .IdxWidth  (IDX_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we_s),
    .waddr(IDX_W'(index_s)),
    .wdata(wdata_r),
    .raddr(IDX_W'(index_s)),
    .rdata(rd_data_s)
  );

  // Transfer FSM: latch setup, count wait states, complete or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      addr_r     <= '0;
      write_r    <= 1'b0;
      wdata_r    <= '0;
      pready_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (psel && !penable) begin
            state_r    <= S_ACCESS;
            addr_r     <= paddr;
            write_r    <= pwrite;
            wdata_r    <= pwdata;
            wait_cnt_r <= WAIT_INIT;
            pready_r   <= (WAIT_INIT == '0);
          end else begin
            pready_r   <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= '0;
            pready_r   <= 1'b0;
          end else if (wait_cnt_r != '0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
            pready_r   <= (wait_cnt_r == 4'd1);
          end else begin
            state_r    <= S_IDLE;
            pready_r   <= 1'b0;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          wait_cnt_r <= '0;
          pready_r   <= 1'b0;
        end
      endcase
    end
  end

  assign pready  = pready_r;
  assign pslverr = pready_r && (err_s != ERR_NONE);
  assign prdata  = (pready_r && (err_s == ERR_NONE)) ? rd_data_s : '0;

endmodule

// File: tb/tb_apb3_mem_completer.sv
// Directed self-checking bench: one DUT with 2 wait states, one with 0 wait states.
module tb_apb3_mem_completer;

  localparam int AW = 20;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] paddr, paddr0;
  logic          psel, penable, pwrite, psel0, penable0, pwrite0;
  logic [DW-1:0] pwdata, pwdata0, prdata, prdata0;
  logic          pready, pslverr, pready0, pslverr0;

  int checks = 0;
  int failures = 0;

  apb3_mem_completer #(.AddressWidth(AW), .DataWidth(DW), .DepthWords(16),
                       .BaseAddress(32'h100), .WaitStates(2)) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr));

  apb3_mem_completer #(.AddressWidth(AW), .DataWidth(DW), .DepthWords(16),
                       .BaseAddress(32'h100), .WaitStates(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr0), .psel(psel0), .penable(penable0),
    .pwrite(pwrite0), .pwdata(pwdata0), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));

  // One APB transfer on bus z (0: 2-wait DUT, 1: 0-wait DUT). Called #1 after a posedge;
  // returns #1 after the completion edge with psel low, so a following call is back-to-back.
  // Address and data are scrambled during the access phase to exercise latching.
  task automatic apb_xfer(input bit z, input logic [AW-1:0] addr, input bit wr,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                          output logic err, output int ncyc);
    ncyc = 0; rd = '0; err = 1'b0;
    if (z) begin paddr0 = addr; pwrite0 = wr; pwdata0 = wd; psel0 = 1'b1; penable0 = 1'b0; end
    else   begin paddr  = addr; pwrite  = wr; pwdata  = wd; psel  = 1'b1; penable  = 1'b0; end
    @(posedge clk); #1;
    if (z) begin penable0 = 1'b1; paddr0 = addr ^ 20'h00040; pwdata0 = ~wd; end
    else   begin penable  = 1'b1; paddr  = addr ^ 20'h00040; pwdata  = ~wd; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((z ? pready0 : pready) === 1'b1) begin
        ncyc = i;
        rd   = z ? prdata0 : prdata;
        err  = z ? pslverr0 : pslverr;
        break;
      end
    end
    if (ncyc == 0) begin
      checks++; failures++;
      $display("FAIL xfer_timeout addr=%h actual=no pready required=pready within 20 cycles", addr);
    end else begin
      @(posedge clk); #1;
    end
    if (z) begin psel0 = 1'b0; penable0 = 1'b0; end
    else   begin psel  = 1'b0; penable  = 1'b0; end
  endtask

  task automatic test_reset();
    checks++;
    if ({pready, pslverr, prdata} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL reset_in actual=%b/%b/%h required=0/0/00000000", pready, pslverr, prdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    // penable without psel while idle must be ignored
    penable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pready, pslverr, prdata, pready0, pslverr0, prdata0} !== {2'b00, 32'h0, 2'b00, 32'h0}) begin
      failures++;
      $display("FAIL reset_out actual=%b/%b/%h %b/%b/%h required=all 0",
               pready, pslverr, prdata, pready0, pslverr0, prdata0);
    end
    @(posedge clk); #1 penable = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] rd; logic err; int n;
    apb_xfer(1'b0, 20'h140, 1'b0, 32'h0, rd, err, n);
    checks++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL oor_read actual=err %b data %h required=err 1 data 00000000", err, rd);
    end
    apb_xfer(1'b0, 20'h0FC, 1'b1, 32'hFFFF_FFFF, rd, err, n);
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL oor_write_err actual=%b required=1", err);
    end
    for (int i = 0; i < 16; i++) begin
      apb_xfer(1'b0, 20'h100 + 20'(i * 4), 1'b0, 32'h0, rd, err, n);
      checks++;
      if ({err, rd} !== {1'b0, 32'h0}) begin
        failures++; $display("FAIL clean_word%0d actual=err %b data %h required=err 0 data 00000000", i, err, rd);
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; logic err; int n;
    apb_xfer(1'b0, 20'h104, 1'b1, 32'hDEAD_BEEF, rd, err, n);
    checks++;
    if (err !== 1'b0 || n !== 3) begin
      failures++; $display("FAIL wr_resp actual=err %b lat %0d required=err 0 lat 3", err, n);
    end
    apb_xfer(1'b0, 20'h104, 1'b0, 32'h0, rd, err, n);
    checks++;
    if ({err, rd} !== {1'b0, 32'hDEAD_BEEF} || n !== 3) begin
      failures++; $display("FAIL rd_resp actual=err %b data %h lat %0d required=err 0 data deadbeef lat 3", err, rd, n);
    end
  endtask

  task automatic test_misaligned();
    logic [DW-1:0] rd; logic err; int n;
    apb_xfer(1'b0, 20'h106, 1'b1, 32'h1111_1111, rd, err, n);
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL misalign_err actual=%b required=1", err);
    end
    apb_xfer(1'b0, 20'h104, 1'b0, 32'h0, rd, err, n);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL misalign_keep actual=%h required=deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back_zero_wait();
    logic [DW-1:0] rd; logic err; int n1, n2;
    apb_xfer(1'b1, 20'h108, 1'b1, 32'h0000_1234, rd, err, n1);
    apb_xfer(1'b1, 20'h108, 1'b0, 32'h0, rd, err, n2);
    checks++;
    if (n1 !== 1 || n2 !== 1) begin
      failures++; $display("FAIL zw_latency actual=%0d,%0d required=1,1", n1, n2);
    end
    checks++;
    if ({err, rd} !== {1'b0, 32'h0000_1234}) begin
      failures++; $display("FAIL zw_read actual=err %b data %h required=err 0 data 00001234", err, rd);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd; logic err; int n; bit seen;
    seen = 1'b0;
    paddr = 20'h10C; pwrite = 1'b1; pwdata = 32'h55; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); seen |= (pready === 1'b1);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (4) begin @(negedge clk); seen |= (pready === 1'b1); end
    checks++;
    if (seen) begin
      failures++; $display("FAIL abort_pready actual=pulse required=no pulse");
    end
    @(posedge clk); #1;
    apb_xfer(1'b0, 20'h10C, 1'b0, 32'h0, rd, err, n);
    checks++;
    if ({err, rd} !== {1'b0, 32'h0} || n !== 3) begin
      failures++; $display("FAIL abort_after actual=err %b data %h lat %0d required=err 0 data 00000000 lat 3", err, rd, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic err; int n; bit got;
    got = 1'b0;
    apb_xfer(1'b0, 20'h100, 1'b1, 32'h0000_00A5, rd, err, n);
    paddr = 20'h100; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pready === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || prdata !== 32'h0000_00A5) begin
      failures++; $display("FAIL rstmid_pre actual=ready %b data %h required=ready 1 data 000000a5", got, prdata);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pready, pslverr, prdata} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL rstmid_async actual=%b/%b/%h required=0/0/00000000", pready, pslverr, prdata);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b0, 20'h100, 1'b0, 32'h0, rd, err, n);
    checks++;
    if ({err, rd} !== {1'b0, 32'h0} || n !== 3) begin
      failures++; $display("FAIL rstmid_read actual=err %b data %h lat %0d required=err 0 data 00000000 lat 3", err, rd, n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    paddr = '0;  psel = 1'b0;  penable = 1'b0;  pwrite = 1'b0;  pwdata = '0;
    paddr0 = '0; psel0 = 1'b0; penable0 = 1'b0; pwrite0 = 1'b0; pwdata0 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_out_of_range();
    test_write_read();
    test_misaligned();
    test_back_to_back_zero_wait();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
